// File: rtl/pipe_divider.sv
// Pipelined restoring integer divider: one operand/abs stage, DIVIDEND_WIDTH/BITS_PER_STAGE
// division stages and one sign-fix output stage, under a single global stall.
module pipe_divider #(
  parameter int unsigned DIVIDEND_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH  = 24,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      ivalid,
  output logic                      iready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  input  logic                      is_signed,
  input  logic [TAG_WIDTH-1:0]      itag,
  output logic                      ovalid,
  input  logic                      oready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_zero,
  output logic [TAG_WIDTH-1:0]      otag
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned NumStages = DW / BITS_PER_STAGE;
  localparam logic [DW-1:0] MinNeg = {1'b1, {(DW-1){1'b0}}};

  // Index 0 is the operand stage, 1..NumStages are the division stages.
  logic                 valid_q [NumStages+1];
  logic [VW-1:0]        rem_q   [NumStages+1];
  logic [DW-1:0]        dq_q    [NumStages+1];
  logic [VW-1:0]        dsr_q   [NumStages+1];
  logic                 qneg_q  [NumStages+1];
  logic                 rneg_q  [NumStages+1];
  logic                 dz_q    [NumStages+1];
  logic                 ovf_q   [NumStages+1];
  logic [TAG_WIDTH-1:0] tag_q   [NumStages+1];

  logic          dvd_neg, dsr_neg, in_dz, in_ovf;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dsr_mag;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;

  assign iready = !(ovalid && !oready);

  // dq holds the unconsumed dividend bits at the top and the quotient bits shifted in below.
  function automatic logic [VW+DW-1:0] div_steps(input logic [VW-1:0] rem_in,
                                                 input logic [DW-1:0] dq_in,
                                                 input logic [VW-1:0] dsr);
    logic [VW-1:0] rem;
    logic [DW-1:0] dq;
    logic [VW:0]   shifted;
    logic [VW-1:0] diff;
    logic          fits;
    rem = rem_in;
    dq  = dq_in;
    for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
      shifted = {rem, dq[DW-1]};
      diff    = shifted[VW-1:0] - dsr;
      fits    = (shifted >= {1'b0, dsr});
      rem     = fits ? diff : shifted[VW-1:0];
      dq      = {dq[DW-2:0], fits};
    end
    return {rem, dq};
  endfunction

  always_comb begin
    in_dz   = (divisor == '0);
    in_ovf  = is_signed && (dividend == MinNeg) && (divisor == '1);
    // A zero divisor keeps the raw dividend so the remainder ends as its low bits.
    dvd_neg = is_signed && dividend[DW-1] && !in_dz;
    dsr_neg = is_signed && divisor[VW-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;
  end

  always_comb begin
    q_fix = qneg_q[NumStages] ? (~dq_q[NumStages] + 1'b1) : dq_q[NumStages];
    r_fix = rneg_q[NumStages] ? (~rem_q[NumStages] + 1'b1) : rem_q[NumStages];
    if (dz_q[NumStages]) q_fix = '1;
    if (ovf_q[NumStages]) begin
      q_fix = MinNeg;
      r_fix = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int k = 0; k <= NumStages; k++) begin
        valid_q[k] <= 1'b0;
        rem_q[k]   <= '0;
        dq_q[k]    <= '0;
        dsr_q[k]   <= '0;
        qneg_q[k]  <= 1'b0;
        rneg_q[k]  <= 1'b0;
        dz_q[k]    <= 1'b0;
        ovf_q[k]   <= 1'b0;
        tag_q[k]   <= '0;
      end
      ovalid    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      otag      <= '0;
    end else if (iready) begin
      valid_q[0] <= ivalid;
      rem_q[0]   <= '0;
      dq_q[0]    <= dvd_mag;
      dsr_q[0]   <= dsr_mag;
      qneg_q[0]  <= (dvd_neg ^ dsr_neg) && !in_dz;
      rneg_q[0]  <= dvd_neg;
      dz_q[0]    <= in_dz;
      ovf_q[0]   <= in_ovf;
      tag_q[0]   <= itag;
      for (int k = 1; k <= NumStages; k++) begin
        valid_q[k]           <= valid_q[k-1];
        {rem_q[k], dq_q[k]}  <= div_steps(rem_q[k-1], dq_q[k-1], dsr_q[k-1]);
        dsr_q[k]             <= dsr_q[k-1];
        qneg_q[k]            <= qneg_q[k-1];
        rneg_q[k]            <= rneg_q[k-1];
        dz_q[k]              <= dz_q[k-1];
        ovf_q[k]             <= ovf_q[k-1];
        tag_q[k]             <= tag_q[k-1];
      end
      ovalid    <= valid_q[NumStages];
      quotient  <= q_fix;
      remainder <= r_fix;
      div_zero  <= dz_q[NumStages];
      otag      <= tag_q[NumStages];
    end
  end

endmodule

// File: tb/tb_pipe_divider.sv
// Directed bench for pipe_divider at 1, 2 and 4 bits per stage; results are collected at the
// output handshake and compared with hand-computed values and a native-division reference.
module tb_pipe_divider;

  localparam int L1 = 34;
  localparam int L2 = 18;
  localparam int L4 = 10;

  typedef struct {
    logic [31:0] q;
    logic [23:0] r;
    logic        dz;
    logic [3:0]  tag;
    int          cyc;
  } res_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ivalid = 1'b0;
  logic [31:0] dividend = '0;
  logic [23:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic [3:0]  itag = '0;
  logic        oready = 1'b1;

  logic        iready_b1, ovalid_b1, div_zero_b1;
  logic [31:0] quotient_b1;
  logic [23:0] remainder_b1;
  logic [3:0]  otag_b1;
  logic        iready_b2, ovalid_b2, div_zero_b2;
  logic [31:0] quotient_b2;
  logic [23:0] remainder_b2;
  logic [3:0]  otag_b2;
  logic        iready_b4, ovalid_b4, div_zero_b4;
  logic [31:0] quotient_b4;
  logic [23:0] remainder_b4;
  logic [3:0]  otag_b4;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  res_t out1[$];
  res_t out2[$];
  res_t out4[$];

  pipe_divider #(.BITS_PER_STAGE(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ivalid(ivalid), .iready(iready_b1),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .itag(itag),
    .ovalid(ovalid_b1), .oready(oready), .quotient(quotient_b1), .remainder(remainder_b1),
    .div_zero(div_zero_b1), .otag(otag_b1)
  );
  pipe_divider #(.BITS_PER_STAGE(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ivalid(ivalid), .iready(iready_b2),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .itag(itag),
    .ovalid(ovalid_b2), .oready(oready), .quotient(quotient_b2), .remainder(remainder_b2),
    .div_zero(div_zero_b2), .otag(otag_b2)
  );
  pipe_divider #(.BITS_PER_STAGE(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ivalid(ivalid), .iready(iready_b4),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .itag(itag),
    .ovalid(ovalid_b4), .oready(oready), .quotient(quotient_b4), .remainder(remainder_b4),
    .div_zero(div_zero_b4), .otag(otag_b4)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic [31:0] q, input logic [23:0] r, input logic dz,
                              input logic [3:0] tag, input int c);
    res_t t;
    t.q = q; t.r = r; t.dz = dz; t.tag = tag; t.cyc = c;
    return t;
  endfunction

  always @(negedge sys_clk) begin
    if (ovalid_b1 && oready)
      out1.push_back(mk(quotient_b1, remainder_b1, div_zero_b1, otag_b1, cyc));
    if (ovalid_b2 && oready)
      out2.push_back(mk(quotient_b2, remainder_b2, div_zero_b2, otag_b2, cyc));
    if (ovalid_b4 && oready)
      out4.push_back(mk(quotient_b4, remainder_b4, div_zero_b4, otag_b4, cyc));
  end

  function automatic void model(input logic [31:0] a, input logic [23:0] b, input logic s,
                                output logic [31:0] q, output logic [23:0] r,
                                output logic dz);
    longint sa, sb, qq, rr;
    dz = 1'b0;
    if (b == 24'd0) begin
      q = '1; r = a[23:0]; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 24'hFF_FFFF) begin
      q = a; r = '0;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      qq = sa / sb; rr = sa % sb;
      q = qq[31:0]; r = rr[23:0];
    end else begin
      q = a / {8'd0, b};
      qq = longint'(a % {8'd0, b});
      r = qq[23:0];
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [23:0] b,
                       input logic s, input logic [3:0] t, output logic acc, output int ac);
    @(posedge sys_clk);
    #1;
    ivalid = v; dividend = a; divisor = b; is_signed = s; itag = t;
    @(negedge sys_clk);
    acc = v && iready_b1;
    ac = cyc;
  endtask

  task automatic idle(input int n);
    @(posedge sys_clk);
    #1;
    ivalid = 1'b0;
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset;
    oready = 1'b1;
    #1 sys_rst = 1'b0;
    #1;
    n_checks++;
    if (ovalid_b1 !== 1'b0) $display("FAIL reset_ovalid async: got %b want 0", ovalid_b1);
    else n_pass++;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (iready_b1 !== 1'b1) $display("FAIL reset_iready: got %b want 1", iready_b1);
    else n_pass++;
    n_checks++;
    if ({quotient_b1, remainder_b1, div_zero_b1, otag_b1} !== '0)
      $display("FAIL reset_outputs: got q=%h r=%h dz=%b tag=%h want all 0",
               quotient_b1, remainder_b1, div_zero_b1, otag_b1);
    else n_pass++;
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_checks++;
    if (iready_b1 !== 1'b1 || ovalid_b1 !== 1'b0)
      $display("FAIL post_reset: got iready=%b ovalid=%b want 1/0", iready_b1, ovalid_b1);
    else n_pass++;
  endtask

  task automatic test_signed_stream;
    logic [31:0] a [3];
    logic [23:0] b [3];
    logic [31:0] eq [3];
    logic [23:0] er [3];
    int ac [3];
    logic acc;
    res_t got[$];
    int lat;
    a = '{32'd123, 32'hFFFF_FF85, 32'hFFFF_FEAD};
    b = '{24'd7, 24'd7, 24'hFF_FFEF};
    eq = '{32'd17, 32'hFFFF_FFEF, 32'd19};
    er = '{24'd4, 24'hFF_FFFC, 24'hFF_FFF0};
    out1.delete(); out2.delete(); out4.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a[i], b[i], 1'b1, 4'(i + 1), acc, ac[i]);
      n_checks++;
      if (acc !== 1'b1) $display("FAIL stream_accept[%0d]: got %b want 1", i, acc);
      else n_pass++;
    end
    idle(40);
    for (int n = 0; n < 3; n++) begin
      case (n)
        0: begin got = out1; lat = L1; end
        1: begin got = out2; lat = L2; end
        default: begin got = out4; lat = L4; end
      endcase
      n_checks++;
      if (got.size() != 3) begin
        $display("FAIL stream_count[bps%0d]: got %0d want 3", 1 << n, got.size());
        continue;
      end
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i].q !== eq[i] || got[i].r !== er[i] || got[i].dz !== 1'b0 ||
            got[i].tag !== 4'(i + 1))
          $display("FAIL stream_result[bps%0d][%0d]: got q=%h r=%h dz=%b tag=%0d want q=%h r=%h dz=0 tag=%0d",
                   1 << n, i, got[i].q, got[i].r, got[i].dz, got[i].tag, eq[i], er[i], i + 1);
        else n_pass++;
        n_checks++;
        if (got[i].cyc - ac[i] != lat)
          $display("FAIL stream_latency[bps%0d][%0d]: got %0d want %0d",
                   1 << n, i, got[i].cyc - ac[i], lat);
        else n_pass++;
      end
    end
  endtask

  task automatic test_unsigned_mix;
    logic acc;
    int ac0, ac1;
    out1.delete();
    drive(1'b1, 32'hFFFF_FF85, 24'd7, 1'b0, 4'd5, acc, ac0);
    drive(1'b1, 32'hFFFF_FF85, 24'd7, 1'b1, 4'd6, acc, ac1);
    idle(40);
    n_checks++;
    if (out1.size() != 2) $display("FAIL mix_count: got %0d want 2", out1.size());
    else begin
      n_pass++;
      n_checks++;
      if (out1[0].q !== 32'h2492_4913 || out1[0].r !== 24'd0 || out1[0].tag !== 4'd5)
        $display("FAIL mix_unsigned: got q=%h r=%h tag=%0d want q=24924913 r=0 tag=5",
                 out1[0].q, out1[0].r, out1[0].tag);
      else n_pass++;
      n_checks++;
      if (out1[1].q !== 32'hFFFF_FFEF || out1[1].r !== 24'hFF_FFFC || out1[1].tag !== 4'd6)
        $display("FAIL mix_signed: got q=%h r=%h tag=%0d want q=ffffffef r=fffffc tag=6",
                 out1[1].q, out1[1].r, out1[1].tag);
      else n_pass++;
      n_checks++;
      if (out1[1].cyc - ac1 != L1)
        $display("FAIL mix_latency: got %0d want %0d", out1[1].cyc - ac1, L1);
      else n_pass++;
    end
  endtask

  task automatic test_corners;
    logic [31:0] a [5];
    logic [23:0] b [5];
    logic        s [5];
    logic [31:0] eq [5];
    logic [23:0] er [5];
    logic        ez [5];
    logic acc;
    int ac;
    a  = '{32'd100, 32'd100, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    b  = '{24'd0, 24'd0, 24'd0, 24'hFF_FFFF, 24'hFF_FFFF};
    s  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    eq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0080};
    er = '{24'd100, 24'd100, 24'hFF_FFFB, 24'd0, 24'h00_0080};
    ez = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    out1.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, a[i], b[i], s[i], 4'(8 + i), acc, ac);
    idle(40);
    n_checks++;
    if (out1.size() != 5) $display("FAIL corner_count: got %0d want 5", out1.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (out1[i].q !== eq[i] || out1[i].r !== er[i] || out1[i].dz !== ez[i] ||
            out1[i].tag !== 4'(8 + i))
          $display("FAIL corner[%0d]: got q=%h r=%h dz=%b tag=%0d want q=%h r=%h dz=%b tag=%0d",
                   i, out1[i].q, out1[i].r, out1[i].dz, out1[i].tag, eq[i], er[i], ez[i], 8 + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    res_t exp[$];
    int starts [3];
    int idx, k, bad_ready, bad_hold;
    logic [31:0] a, hq;
    logic [23:0] b, hr;
    logic s, stall, held, hz;
    logic [3:0] ht;
    logic [31:0] mq;
    logic [23:0] mr;
    logic mz;
    out1.delete();
    for (int j = 0; j < 3; j++) starts[j] = $urandom_range(36 + j * 20, 44 + j * 20);
    idx = 0; k = 0; bad_ready = 0; bad_hold = 0; held = 1'b0;
    a = $urandom; b = 24'd3; s = 1'b1;
    while ((idx < 40 || out1.size() < 40) && k < 3000) begin
      @(posedge sys_clk);
      #1;
      stall = 1'b0;
      for (int j = 0; j < 3; j++) if (k >= starts[j] && k < starts[j] + 5) stall = 1'b1;
      oready = !stall;
      ivalid = (idx < 40);
      dividend = a; divisor = b; is_signed = s; itag = 4'(idx % 16);
      @(negedge sys_clk);
      n_checks++;
      if (iready_b1 !== !(ovalid_b1 && !oready)) begin
        $display("FAIL bp_iready[k=%0d]: got %b want %b", k, iready_b1, !(ovalid_b1 && !oready));
        bad_ready++;
      end else n_pass++;
      if (held) begin
        n_checks++;
        if (ovalid_b1 !== 1'b1 || quotient_b1 !== hq || remainder_b1 !== hr ||
            div_zero_b1 !== hz || otag_b1 !== ht) begin
          $display("FAIL bp_hold[k=%0d]: got v=%b q=%h r=%h want v=1 q=%h r=%h",
                   k, ovalid_b1, quotient_b1, remainder_b1, hq, hr);
          bad_hold++;
        end else n_pass++;
      end
      held = ovalid_b1 && !oready;
      hq = quotient_b1; hr = remainder_b1; hz = div_zero_b1; ht = otag_b1;
      if (ivalid && iready_b1) begin
        model(a, b, s, mq, mr, mz);
        exp.push_back(mk(mq, mr, mz, 4'(idx % 16), 0));
        idx++;
        a = $urandom;
        b = 24'($urandom);
        if (idx % 3 == 0) b = 24'($urandom_range(1, 300));
        if (idx % 7 == 0) b = 24'hFF_FFFF - 24'($urandom_range(0, 40));
        if (idx == 20) b = 24'd0;
        s = 1'($urandom % 2);
      end
      k++;
    end
    oready = 1'b1;
    ivalid = 1'b0;
    n_checks++;
    if (k >= 3000) $display("FAIL bp_timeout: got %0d results want 40", out1.size());
    else n_pass++;
    n_checks++;
    if (out1.size() != 40 || exp.size() != 40)
      $display("FAIL bp_count: got %0d want 40", out1.size());
    else begin
      n_pass++;
      for (int i = 0; i < 40; i++) begin
        n_checks++;
        if (out1[i].q !== exp[i].q || out1[i].r !== exp[i].r || out1[i].dz !== exp[i].dz ||
            out1[i].tag !== exp[i].tag)
          $display("FAIL bp_result[%0d]: got q=%h r=%h dz=%b tag=%0d want q=%h r=%h dz=%b tag=%0d",
                   i, out1[i].q, out1[i].r, out1[i].dz, out1[i].tag,
                   exp[i].q, exp[i].r, exp[i].dz, exp[i].tag);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic acc;
    int ac;
    out1.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 32'(1000 + i), 24'd3, 1'b0, 4'(i), acc, ac);
    @(posedge sys_clk);
    #1 ivalid = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    #1;
    n_checks++;
    if (ovalid_b1 !== 1'b0 || iready_b1 !== 1'b1)
      $display("FAIL midreset_immediate: got ovalid=%b iready=%b want 0/1", ovalid_b1, iready_b1);
    else n_pass++;
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    repeat (45) @(negedge sys_clk);
    n_checks++;
    if (out1.size() != 0) $display("FAIL midreset_flushed: got %0d results want 0", out1.size());
    else n_pass++;
    drive(1'b1, 32'd50, 24'd7, 1'b0, 4'd12, acc, ac);
    idle(40);
    n_checks++;
    if (out1.size() != 1) $display("FAIL midreset_next_count: got %0d want 1", out1.size());
    else begin
      n_pass++;
      n_checks++;
      if (out1[0].q !== 32'd7 || out1[0].r !== 24'd1 || out1[0].tag !== 4'd12 ||
          out1[0].cyc - ac != L1)
        $display("FAIL midreset_next: got q=%h r=%h tag=%0d lat=%0d want q=7 r=1 tag=12 lat=%0d",
                 out1[0].q, out1[0].r, out1[0].tag, out1[0].cyc - ac, L1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_signed_stream();
    test_unsigned_mix();
    test_corners();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_divider.md
PIPE_DIVIDER -- requirements
Module: pipe_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 32, dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 24, divisor and remainder width; legal only if DIVISOR_WIDTH <= DIVIDEND_WIDTH.
REQ-003 SHALL have parameter BITS_PER_STAGE, default 1, quotient bits resolved per pipeline stage; legal only if it divides DIVIDEND_WIDTH.
REQ-004 SHALL have parameter TAG_WIDTH, default 4, width of the sideband tag.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: sys_clk  in  1  clock, rising edge.
REQ-006 sys_rst  in  1  asynchronous active-low reset.
REQ-007 ivalid  in  1  input operands valid.
REQ-008 iready  out  1  block accepts input this cycle.
REQ-009 dividend  in  DIVIDEND_WIDTH  numerator.
REQ-010 divisor  in  DIVISOR_WIDTH  denominator.
REQ-011 is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-012 itag  in  TAG_WIDTH  sideband tag, carried unchanged.
REQ-013 ovalid  out  1  result valid.
REQ-014 oready  in  1  downstream accepts result.
REQ-015 quotient  out  DIVIDEND_WIDTH  quotient.
REQ-016 remainder  out  DIVISOR_WIDTH  remainder.
REQ-017 div_zero  out  1  divisor was zero.
REQ-018 otag  out  TAG_WIDTH  tag of this result.

Function
REQ-019 Latency SHALL be L = DIVIDEND_WIDTH/BITS_PER_STAGE + 2 cycles from accepted input to ovalid while never stalled: 1 operand/abs stage, DIVIDEND_WIDTH/BITS_PER_STAGE restoring-division stages, 1 sign-fix/output stage.
REQ-020 Throughput SHALL be one transaction per cycle; transfer occurs on ivalid && iready at input and ovalid && oready at output.
REQ-021 Global stall: iready = !(ovalid && !oready); all pipeline stages, valid bits included, SHALL hold when iready is 0.
REQ-022 Results SHALL leave in acceptance order; no transaction dropped or duplicated under any oready pattern.
REQ-023 Outputs SHALL be registered and stable while ovalid && !oready.
REQ-024 Signed mode: operands sign-extended to internal magnitudes; quotient truncates toward zero; remainder sign equals dividend sign; dividend = quotient*divisor + remainder.
REQ-025 Unsigned mode: operands zero-extended; standard floor division.
REQ-026 Divisor zero (either mode): quotient all ones, remainder = dividend[DIVISOR_WIDTH-1:0], div_zero = 1; otherwise div_zero = 0.
REQ-027 Signed overflow (dividend = most negative value, divisor = all ones): quotient = dividend unchanged, remainder = 0, div_zero = 0.
REQ-028 is_signed, itag, div_zero and overflow flags SHALL travel in the pipeline with their operands; per-transaction mode mixing at full rate SHALL be correct.
REQ-029 Bubbles (ivalid = 0) SHALL propagate as invalid slots; values of operand and tag inputs are ignored when ivalid = 0.

Reset
REQ-030 While sys_rst = 0: all valid bits, ovalid, quotient, remainder, div_zero, otag SHALL be 0, asynchronously.
REQ-031 iready SHALL be 1 during and after reset.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions; no ovalid until a new input is accepted and L cycles elapse.

Verification
REQ-033 Signed stream, oready = 1, back-to-back: 123/7 -> q 17 r 4; -123/7 -> q 0xFFFFFFEF r 0xFFFFFC; -339/-17 -> q 19 r 0xFFFFF0; each ovalid exactly L cycles after acceptance, in order.
REQ-034 Unsigned: 0xFFFFFF85/7 -> q 0x24924913 r 0; the same operands with is_signed = 1 in the next cycle -> q 0xFFFFFFEF r 0xFFFFFC.
REQ-035 Corners: 100/0 -> q 0xFFFFFFFF r 100 div_zero 1; 0x80000000/0xFFFFFF signed -> q 0x80000000 r 0 div_zero 0.
REQ-036 Backpressure: 40 random transactions with tags 0..15 cycling, oready low for 5 cycles at random points -> iready low exactly while ovalid && !oready, all 40 results match the golden model, tags in order.
REQ-037 Reset pulse while 5 transactions are in flight -> ovalid 0 immediately, none of the 5 ever emitted, the next accepted transaction emitted after L cycles.
REQ-038 Repeat REQ-033 with BITS_PER_STAGE = 2 and 4 -> identical results, latency 18 and 10.
